tsu_queue_reader: RTL
=====================

Name: tsu_queue_reader

Overview:
- Host-side drain engine for the TSU timestamp queue. It is the reading end of the tsu q_rd_* interface.
- It watches q_rd_stat, pops one 128-bit timestamp entry at a time into a holding register, and presents it to a CPU-style register port as four 32-bit words plus a status word.
- It sits in the q_rd_clk domain between one tsu instance (RX or TX) and the host bus.

Parameters:
- RD_LAT, 1: q_rd_clk cycles from q_rd_en high to q_rd_data valid. Legal range 1..3.
- IRQ_THRESH, 4: pending-entry count that raises irq (optional feature only).
- IRQ_TIMEOUT, 1024: cycles a valid entry may wait before irq is forced (optional feature only).

Ports:
- q_rd_clk  in  1  sole clock.
- q_rst_n  in  1  reset, asynchronous, active-low.
- q_rd_stat  in  8  tsu queue fill count; 0 = empty.
- q_rd_data  in  128  tsu queue read data, valid RD_LAT cycles after q_rd_en.
- q_rd_en  out  1  one-cycle pop strobe to tsu queue.
- host_rd  in  1  host read strobe, one cycle.
- host_wr  in  1  host write strobe, one cycle.
- host_addr  in  3  word select: 0 status, 1..4 entry words.
- host_wdata  in  32  write data; only addr 0 bit0 (flush) is used.
- host_rdata  out  32  registered read data, valid the cycle after host_rd.
- entry_valid  out  1  holding register contains an unread entry.
- irq  out  1  present only with TSU_QRD_IRQ_EN.

Behaviour:
- Reset (q_rst_n low, asynchronous) forces the following; it may arrive mid-operation at any state:
  - state=IDLE.
  - q_rd_en=0, host_rdata=0, entry_valid=0, irq=0.
  - holding=0, rd_count=0, lat_cnt=0.
  - An in-flight pop is abandoned; returning data is ignored.
- FSM states and transitions:
  - IDLE: if !entry_valid && q_rd_stat!=0, assert q_rd_en for exactly one cycle and go to WAIT with lat_cnt=RD_LAT.
  - WAIT: decrement lat_cnt each cycle. When it reaches 0, capture q_rd_data into holding, set entry_valid, increment rd_count (8-bit, wraps 255->0), and go to FULL.
  - FULL: remain there until the host consumes or flushes the entry, then clear entry_valid and return to IDLE.
- Pop rules:
  - q_rd_en never asserts while entry_valid=1 or while in WAIT. At most one pop is outstanding.
  - Minimum interval between pops is RD_LAT+2 cycles.
- Host read map (host_rdata is updated on the cycle after host_rd):
  - addr0: {entry_valid, 15'b0, q_rd_stat, rd_count}.
  - addr1: holding[127:96].
  - addr2: holding[95:64].
  - addr3: holding[63:32].
  - addr4: holding[31:0].
  - addr5..7: 0.
  - addr1..4 with entry_valid=0: 0.
- Consume: host_rd at addr4 while entry_valid=1 returns word 3, clears entry_valid on the same edge, and moves FSM to IDLE. The next pop can start the following cycle.
- Flush: host_wr to addr0 with host_wdata[0]=1.
  - In FULL: discards the entry with no data returned.
  - In WAIT: completes the capture and immediately discards it.
  - rd_count still increments in both cases.
  - Writes to other addresses are ignored.
- Simultaneous events:
  - host_rd at addr4 and a flush in the same cycle: the read returns data, and the entry is cleared once.
  - host_rd at addr0 during the consume cycle returns pre-clear status.
- No read-side errors. Out-of-order word reads are allowed; only the addr4 read consumes.

Optional Feature:
- Macro TSU_QRD_IRQ_EN.
- Defined:
  - irq port exists; irq is registered.
  - irq=1 while entry_valid && ((q_rd_stat+1) >= IRQ_THRESH || wait_cnt >= IRQ_TIMEOUT).
  - wait_cnt is a 16-bit counter. It clears when entry_valid=0 and saturates at IRQ_TIMEOUT.
  - irq drops the cycle after entry_valid clears.
- Undefined: irq port and wait_cnt are absent. All other behaviour is identical.

Test Plan:
- Reset then idle: hold q_rd_stat=0 for 100 cycles -> q_rd_en never asserts, entry_valid=0, addr0 read returns 0x00000000.
- Single entry: q_rd_stat=1, RD_LAT=1, data=0x0123_4567_89AB_CDEF_0011_2233_4455_6677.
  - Required: exactly one q_rd_en pulse, entry_valid rises 2 cycles later.
  - Reads of addr1..4 return 0x01234567, 0x89ABCDEF, 0x00112233, 0x44556677.
  - After the addr4 read, entry_valid=0 and addr0 read gives rd_count=1.
- Back-to-back drain: q_rd_stat=3, host consumes each entry immediately -> 3 pops, each pop no earlier than 1 cycle after the previous addr4 read, rd_count=3, no pop while entry_valid=1.
- Flush and wrap: preset rd_count=255, then flush in FULL -> entry discarded, rd_count=0, next pop issued.
  - Repeat with the flush landing in WAIT at RD_LAT=3 -> same result, and q_rd_data is ignored after the flush.
- Reset mid-WAIT: deassert q_rst_n between q_rd_en and capture -> all outputs 0 immediately (asynchronous), and no capture after release.
- IRQ (TSU_QRD_IRQ_EN defined, THRESH=4, TIMEOUT=16):
  - q_rd_stat=3 with an entry held -> irq=1.
  - q_rd_stat=0 with an entry held -> irq=1 after 16 cycles.
  - Consume -> irq=0 the next cycle.

Source files
------------

// File: rtl/tsu_queue_reader.sv
// Host-side drain engine for the TSU timestamp queue: pops one 128-bit entry at a time
// into a holding register exposed as four 32-bit words. Define TSU_QRD_IRQ_EN to add irq.
module tsu_queue_reader #(
    parameter int RD_LAT = 1
`ifdef TSU_QRD_IRQ_EN
    ,
    parameter int IRQ_THRESH  = 4,
    parameter int IRQ_TIMEOUT = 1024
`endif
) (
    input  logic         q_rd_clk,
    input  logic         q_rst_n,
    input  logic [7:0]   q_rd_stat,
    input  logic [127:0] q_rd_data,
    output logic         q_rd_en,
    input  logic         host_rd,
    input  logic         host_wr,
    input  logic [2:0]   host_addr,
    input  logic [31:0]  host_wdata,
    output logic [31:0]  host_rdata,
    output logic         entry_valid
`ifdef TSU_QRD_IRQ_EN
    ,
    output logic         irq
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, FULL} state_t;

    localparam logic [1:0] LAT_INIT = 2'(RD_LAT);

    state_t         state_q, state_d;
    logic           q_rd_en_q, q_rd_en_d;
    logic [31:0]    host_rdata_q, host_rdata_d;
    logic           entry_valid_q, entry_valid_d;
    logic [127:0]   holding_q, holding_d;
    logic [7:0]     rd_count_q, rd_count_d;
    logic [1:0]     lat_cnt_q, lat_cnt_d;
    logic           flush_pend_q, flush_pend_d;
    logic           consume;
    logic           flush;
    logic [31:0]    rd_word;
    logic           unused_wdata;

    assign unused_wdata = ^host_wdata[31:1];

    always_comb begin
        consume = host_rd && (host_addr == 3'd4) && entry_valid_q;
        flush   = host_wr && (host_addr == 3'd0) && host_wdata[0];

        case (host_addr)
            3'd0:    rd_word = {entry_valid_q, 15'b0, q_rd_stat, rd_count_q};
            3'd1:    rd_word = entry_valid_q ? holding_q[127:96] : 32'h0;
            3'd2:    rd_word = entry_valid_q ? holding_q[95:64]  : 32'h0;
            3'd3:    rd_word = entry_valid_q ? holding_q[63:32]  : 32'h0;
            3'd4:    rd_word = entry_valid_q ? holding_q[31:0]   : 32'h0;
            default: rd_word = 32'h0;
        endcase
    end

    // A flush seen while a pop is in flight is remembered so the returning entry is counted but dropped.
    always_comb begin
        state_d       = state_q;
        q_rd_en_d     = 1'b0;
        host_rdata_d  = host_rd ? rd_word : host_rdata_q;
        entry_valid_d = entry_valid_q;
        holding_d     = holding_q;
        rd_count_d    = rd_count_q;
        lat_cnt_d     = lat_cnt_q;
        flush_pend_d  = flush_pend_q;

        case (state_q)
            IDLE: begin
                if (!entry_valid_q && (q_rd_stat != 8'd0)) begin
                    q_rd_en_d    = 1'b1;
                    lat_cnt_d    = LAT_INIT;
                    flush_pend_d = 1'b0;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_q != 2'd0) begin
                    lat_cnt_d    = lat_cnt_q - 2'd1;
                    flush_pend_d = flush_pend_q | flush;
                end else begin
                    rd_count_d   = rd_count_q + 8'd1;
                    flush_pend_d = 1'b0;
                    if (flush_pend_q || flush) begin
                        state_d = IDLE;
                    end else begin
                        holding_d     = q_rd_data;
                        entry_valid_d = 1'b1;
                        state_d       = FULL;
                    end
                end
            end
            FULL: begin
                if (consume || flush) begin
                    entry_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge q_rd_clk or negedge q_rst_n) begin
        if (!q_rst_n) begin
            state_q       <= IDLE;
            q_rd_en_q     <= 1'b0;
            host_rdata_q  <= 32'h0;
            entry_valid_q <= 1'b0;
            holding_q     <= 128'h0;
            rd_count_q    <= 8'h0;
            lat_cnt_q     <= 2'd0;
            flush_pend_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            q_rd_en_q     <= q_rd_en_d;
            host_rdata_q  <= host_rdata_d;
            entry_valid_q <= entry_valid_d;
            holding_q     <= holding_d;
            rd_count_q    <= rd_count_d;
            lat_cnt_q     <= lat_cnt_d;
            flush_pend_q  <= flush_pend_d;
        end
    end

    assign q_rd_en     = q_rd_en_q;
    assign host_rdata  = host_rdata_q;
    assign entry_valid = entry_valid_q;

`ifdef TSU_QRD_IRQ_EN
    localparam logic [15:0] WAIT_MAX = 16'(IRQ_TIMEOUT);

    logic        irq_q, irq_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;

    // Fill count includes the held entry, hence the +1; 9 bits so a full queue cannot wrap.
    always_comb begin
        wait_cnt_d = 16'h0;
        if (entry_valid_q) begin
            wait_cnt_d = (wait_cnt_q >= WAIT_MAX) ? WAIT_MAX : wait_cnt_q + 16'd1;
        end
        irq_d = entry_valid_q &&
                ((({1'b0, q_rd_stat} + 9'd1) >= 9'(IRQ_THRESH)) || (wait_cnt_q >= WAIT_MAX));
    end

    always_ff @(posedge q_rd_clk or negedge q_rst_n) begin
        if (!q_rst_n) begin
            irq_q      <= 1'b0;
            wait_cnt_q <= 16'h0;
        end else begin
            irq_q      <= irq_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule
